// File: rtl/day_count_scan.sv
// Three-digit BCD day counter with prescaler, manual advance and a
// time-multiplexed display scanner feeding a downstream 7-segment decoder.
module day_count_scan #(
  parameter int TICKS_PER_DAY = 50_000_000,
  parameter int SCAN_DIV      = 50_000,
  parameter int MAX_DAY       = 365
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       adv,
  input  logic       clr,
  output logic [3:0] digit,
  output logic [2:0] anode,
  output logic       day_tick,
  output logic       wrap
);
  localparam int PW = (TICKS_PER_DAY > 2) ? $clog2(TICKS_PER_DAY) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICKS_PER_DAY - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0] MAX_H = 4'(MAX_DAY / 100);
  localparam logic [3:0] MAX_T = 4'((MAX_DAY / 10) % 10);
  localparam logic [3:0] MAX_O = 4'(MAX_DAY % 10);
  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [1:0] SEL_ONES = 2'd0;
  localparam logic [1:0] SEL_TENS = 2'd1;
  localparam logic [1:0] SEL_HUND = 2'd2;

  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic [3:0]    digit_q, digit_d;
  logic [2:0]    anode_q, anode_d;
  logic          day_tick_q, day_tick_d, wrap_q, wrap_d;
  logic          tick, adv_int, at_max;

  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (en) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
    // tick and adv on the same cycle merge into a single increment
    adv_int    = tick | adv;
    at_max     = (hund_q == MAX_H) && (tens_q == MAX_T) && (ones_q == MAX_O);
    hund_d     = hund_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    day_tick_d = 1'b0;
    wrap_d     = 1'b0;
    if (clr) begin
      hund_d = '0;
      tens_d = '0;
      ones_d = '0;
      pre_d  = '0;
    end else if (adv_int) begin
      day_tick_d = 1'b1;
      if (at_max) begin
        hund_d = '0;
        tens_d = '0;
        ones_d = '0;
        wrap_d = 1'b1;
      end else if (ones_q != 4'd9) begin
        ones_d = ones_q + 4'd1;
      end else begin
        ones_d = '0;
        if (tens_q != 4'd9) begin
          tens_d = tens_q + 4'd1;
        end else begin
          tens_d = '0;
          hund_d = hund_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    scan_d = scan_q + SW'(1);
    sel_d  = sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      sel_d  = (sel_q == SEL_HUND) ? SEL_ONES : sel_q + 2'd1;
    end
    // anode and digit come from the same sel so they always move together
    case (sel_q)
      SEL_ONES: begin
        anode_d = 3'b110;
        digit_d = ones_q;
      end
      SEL_TENS: begin
        anode_d = 3'b101;
        digit_d = ((hund_q == 4'd0) && (tens_q == 4'd0)) ? BLANK : tens_q;
      end
      default: begin
        anode_d = 3'b011;
        digit_d = (hund_q == 4'd0) ? BLANK : hund_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      scan_q     <= '0;
      sel_q      <= SEL_ONES;
      hund_q     <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      digit_q    <= 4'h0;
      anode_q    <= 3'b110;
      day_tick_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      scan_q     <= scan_d;
      sel_q      <= sel_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      digit_q    <= digit_d;
      anode_q    <= anode_d;
      day_tick_q <= day_tick_d;
      wrap_q     <= wrap_d;
    end
  end

  assign digit    = digit_q;
  assign anode    = anode_q;
  assign day_tick = day_tick_q;
  assign wrap     = wrap_q;
endmodule

// File: tb/tb_day_count_scan.sv
// Directed bench for day_count_scan: display expectations are queued when the
// count is changed and popped when the scanned display is read back.
module tb_day_count_scan;
  logic       clk, rst_n, en, adv, clr;
  logic [3:0] digit;
  logic [2:0] anode;
  logic       day_tick, wrap;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  logic [11:0] sb[$];

  day_count_scan #(.TICKS_PER_DAY(8), .SCAN_DIV(4), .MAX_DAY(365)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .adv(adv), .clr(clr),
    .digit(digit), .anode(anode), .day_tick(day_tick), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nxt(input int c);
    return (c == 365) ? 0 : c + 1;
  endfunction

  // expected {hund, tens, ones} display codes with leading-zero blanking
  function automatic logic [11:0] disp(input int c);
    logic [3:0] h, t, o;
    h = 4'(c / 100);
    t = 4'((c / 10) % 10);
    o = 4'(c % 10);
    return {(h == 0) ? 4'hF : h, (h == 0 && t == 0) ? 4'hF : t, o};
  endfunction

  function automatic int anode_idx(input logic [2:0] a);
    case (a)
      3'b110:  return 0;
      3'b101:  return 1;
      3'b011:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic read_disp(input string tag);
    logic [3:0]  got[3];
    logic [11:0] e;
    int idx;
    e = sb.pop_front();
    got[0] = 4'h0; got[1] = 4'h0; got[2] = 4'h0;
    step(); step();
    for (int i = 0; i < 12; i++) begin
      step();
      idx = anode_idx(anode);
      chk({tag, "_onehot"}, int'(idx >= 0), 1);
      if (idx >= 0) got[idx] = digit;
    end
    chk({tag, "_hund"}, got[2], e[11:8]);
    chk({tag, "_tens"}, got[1], e[7:4]);
    chk({tag, "_ones"}, got[0], e[3:0]);
  endtask

  task automatic pulse(output logic t, output logic w, output logic t2);
    adv = 1'b1;
    step();
    t = day_tick;
    w = wrap;
    adv = 1'b0;
    step();
    t2 = day_tick | wrap;
    exp_cnt = nxt(exp_cnt);
  endtask

  task automatic advance_to(input int target);
    logic t, w, t2;
    while (exp_cnt != target) pulse(t, w, t2);
  endtask

  initial begin
    logic t, w, t2;
    int nt, changes, found;
    logic [2:0] prev;
    rst_n = 1'b0; en = 1'b0; adv = 1'b0; clr = 1'b0;
    #12;
    chk("rst_digit", digit, 4'h0);
    chk("rst_anode", anode, 3'b110);
    chk("rst_tick", day_tick, 0);
    chk("rst_wrap", wrap, 0);

    // 1: prescaler advance after 8 clocks
    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b1;
    nt = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (day_tick) nt++;
      if (i == 8) chk("t1_tick_at8", day_tick, 1);
    end
    en = 1'b0;
    chk("t1_tick_count", nt, 1);
    exp_cnt = 1;
    sb.push_back(disp(exp_cnt));
    read_disp("t1_disp001");

    // 2: BCD carries
    advance_to(9);
    pulse(t, w, t2);
    chk("t2_tick_010", t, 1);
    chk("t2_wrap_010", w, 0);
    sb.push_back(disp(exp_cnt));
    read_disp("t2_disp010");
    advance_to(99);
    pulse(t, w, t2);
    chk("t2_wrap_100", w, 0);
    sb.push_back(disp(exp_cnt));
    read_disp("t2_disp100");

    // 3: wrap at MAX_DAY
    advance_to(365);
    sb.push_back(disp(exp_cnt));
    read_disp("t3_disp365");
    pulse(t, w, t2);
    chk("t3_tick", t, 1);
    chk("t3_wrap", w, 1);
    chk("t3_pulse_len", t2, 0);
    sb.push_back(disp(exp_cnt));
    read_disp("t3_disp000");

    // 4: adv coincident with prescaler terminal
    en = 1'b1;
    nt = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (day_tick) nt++;
    end
    chk("t4_no_early_tick", nt, 0);
    adv = 1'b1;
    step();
    chk("t4_tick", day_tick, 1);
    adv = 1'b0; en = 1'b0;
    step();
    chk("t4_single_tick", day_tick, 0);
    exp_cnt = nxt(exp_cnt);
    sb.push_back(disp(exp_cnt));
    read_disp("t4_disp001");

    // 5: clr beats adv; en=0 holds count while scan rotates
    advance_to(42);
    sb.push_back(disp(exp_cnt));
    read_disp("t5_disp042");
    clr = 1'b1; adv = 1'b1;
    step();
    chk("t5_clr_tick", day_tick, 0);
    chk("t5_clr_wrap", wrap, 0);
    clr = 1'b0; adv = 1'b0;
    exp_cnt = 0;
    changes = 0;
    prev = anode;
    for (int i = 0; i < 20; i++) begin
      step();
      if (anode != prev) changes++;
      prev = anode;
      if (day_tick) nt++;
    end
    chk("t5_scan_rotates", int'(changes == 4 || changes == 5), 1);
    sb.push_back(disp(exp_cnt));
    read_disp("t5_disp_hold");
    // clr also restarts the prescaler
    en = 1'b1;
    step(); step(); step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    nt = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (day_tick) nt++;
    end
    chk("t5_pre_cleared", nt, 0);
    step();
    chk("t5_pre_tick", day_tick, 1);
    en = 1'b0;
    exp_cnt = nxt(exp_cnt);
    sb.push_back(disp(exp_cnt));
    read_disp("t5_disp001");

    // 6: async reset while tens is selected, then scan order
    found = 0;
    for (int i = 0; i < 16 && found == 0; i++) begin
      step();
      if (anode == 3'b101) found = 1;
    end
    chk("t6_found_tens", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_digit", digit, 4'h0);
    chk("t6_async_anode", anode, 3'b110);
    chk("t6_async_tick", day_tick, 0);
    #1 rst_n = 1'b1;
    exp_cnt = 0;
    for (int k = 1; k <= 24; k++) begin
      logic [11:0] e;
      int s;
      step();
      s = ((k - 1) / 4) % 3;
      e = disp(exp_cnt);
      chk($sformatf("t6_anode_k%0d", k), anode, (s == 0) ? 3'b110 : (s == 1) ? 3'b101 : 3'b011);
      chk($sformatf("t6_digit_k%0d", k), digit, e[s*4 +: 4]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
